// File: rtl/if_id_stage.sv
// Fetch stage: PC register, IF/ID pipeline register, load-use stall and branch/jump redirect.
// Optional hazard counters are built when IF_ID_HAZARD_STATS_EN is defined.
module if_id_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] instr_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        ID_EX_MemRead_i,
  input  logic [4:0]  ID_EX_RT_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        stall_o,
`ifdef IF_ID_HAZARD_STATS_EN
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
`endif
  output logic        ctrl_bubble_o
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_instr, w_instr_next;
  logic [31:0] r_pc4, w_pc4_next;
  logic [31:0] w_pc_plus4;
  logic        w_hazard;
  logic        w_stall;
  logic        w_flush;

  assign w_pc_plus4 = r_pc + 32'd4;

  // rt == 0 is excluded: writes to register zero never create a dependency.
  assign w_hazard = ID_EX_MemRead_i && (ID_EX_RT_i != 5'd0) &&
                    ((ID_EX_RT_i == r_instr[25:21]) || (ID_EX_RT_i == r_instr[20:16]));
  assign w_stall  = w_hazard && (r_state == StRun);
  assign w_flush  = (r_state == StRun) && !w_stall && (jump_i || branch_i);

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_instr_next = r_instr;
    w_pc4_next   = r_pc4;
    unique case (r_state)
      StIdle: begin
        w_instr_next = NOP_INSTR;
        w_pc4_next   = 32'd0;
        if (start_i) w_state_next = StRun;
      end
      StRun: begin
        if (!start_i) begin
          // Dropping start wins over a pending stall; the PC holds.
          w_state_next = StIdle;
          w_instr_next = NOP_INSTR;
          w_pc4_next   = 32'd0;
        end else if (w_stall) begin
          // Hold everything; redirects wait until ID operands are valid.
        end else if (jump_i) begin
          w_pc_next    = jump_target_i;
          w_instr_next = NOP_INSTR;
          w_pc4_next   = 32'd0;
        end else if (branch_i) begin
          w_pc_next    = branch_target_i;
          w_instr_next = NOP_INSTR;
          w_pc4_next   = 32'd0;
        end else begin
          w_pc_next    = w_pc_plus4;
          w_instr_next = instr_i;
          w_pc4_next   = w_pc_plus4;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= StIdle;
      r_pc    <= PC_RESET;
      r_instr <= NOP_INSTR;
      r_pc4   <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_instr <= w_instr_next;
      r_pc4   <= w_pc4_next;
    end
  end

`ifdef IF_ID_HAZARD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  logic w_unused_flush;
  assign w_unused_flush = w_flush;
`endif

  assign pc_o          = r_pc;
  assign instr_o       = r_instr;
  assign pc4_o         = r_pc4;
  assign stall_o       = w_stall;
  assign ctrl_bubble_o = w_stall || (r_state == StIdle);

endmodule
